// File: rtl/lfsr_dbseq.sv
// Full-period (de Bruijn) Fibonacci LFSR with a runtime-programmable feedback mask.
// Optional simulation-only checks are compiled in when LFSR_ASSERT_EN is defined.
module lfsr_dbseq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic [WIDTH-1:0] taps,
  output logic [WIDTH-1:0] seq
);

  logic             fb;
  logic             z;
  logic [WIDTH-1:0] seq_next;

  // z splices the all-zeros state between 0b100..0 and 0b00..01
  always_comb begin
    fb       = ^(seq & taps);
    z        = (seq[WIDTH-2:0] == '0);
    seq_next = {seq[WIDTH-2:0], fb ^ z};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seq <= WIDTH'(1);
    end else if (enable) begin
      seq <= seq_next;
    end
  end

`ifdef LFSR_ASSERT_EN
  generate
    if (WIDTH < 2) begin : g_width_chk
      $error("lfsr_dbseq: WIDTH must be at least 2");
    end
  endgenerate

  always @(posedge clk) begin
    if (rst_n && enable && (taps[WIDTH-1] !== 1'b1))
      $error("lfsr_dbseq: taps[WIDTH-1] is not set on an enabled step");
    if (rst_n && $isunknown(seq))
      $error("lfsr_dbseq: seq contains X/Z while out of reset");
  end
`else
`endif

endmodule

// File: tb/tb_lfsr_dbseq.sv
// Self-checking bench for lfsr_dbseq (WIDTH=8): vector table through a scoreboard
// queue, plus hand-written reset, hold, full-period and zero-insertion sequences.
module tb_lfsr_dbseq;

  localparam int W = 8;
  localparam logic [W-1:0] TAPS_REF = 8'h8E;

  logic         clk;
  logic         rst_n;
  logic         enable;
  logic [W-1:0] taps;
  logic [W-1:0] seq;

  int n_checks = 0;
  int n_fail   = 0;

  logic [W-1:0] exp_q[$];

  typedef struct {
    logic         en;
    logic [W-1:0] tp;
    logic [W-1:0] exp_seq;
  } vec_t;

  vec_t vecs[12];

  lfsr_dbseq #(.WIDTH(W)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .enable (enable),
    .taps   (taps),
    .seq    (seq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: seq=%h expected=%h at %0t", name, act, req, $time);
    end
  endtask

  // drive one cycle, push the expectation, pop and compare after the edge
  task automatic apply(input string name, input logic en, input logic [W-1:0] tp,
                       input logic [W-1:0] exp_seq);
    logic [W-1:0] e;
    @(negedge clk);
    enable = en;
    taps   = tp;
    exp_q.push_back(exp_seq);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check(name, seq, e);
  endtask

  task automatic do_reset();
    @(negedge clk);
    enable = 1'b0;
    rst_n  = 1'b0;
    @(negedge clk);
    rst_n  = 1'b1;
  endtask

  logic [255:0] hit;
  int           dups;
  int           steps;
  logic [W-1:0] v;

  initial begin
    rst_n  = 1'b1;
    enable = 1'b0;
    taps   = TAPS_REF;

    // reset: seq=01 while low and after release with enable low
    #2 rst_n = 1'b0;
    #1 check("reset_during", seq, 8'h01);
    @(negedge clk);
    rst_n = 1'b1;
    apply("reset_after", 1'b0, TAPS_REF, 8'h01);
    apply("reset_hold",  1'b0, TAPS_REF, 8'h01);

    // vector table, starting from 01
    vecs[0]  = '{1'b1, 8'h8E, 8'h02};
    vecs[1]  = '{1'b1, 8'h8E, 8'h05};
    vecs[2]  = '{1'b0, 8'h8E, 8'h05};
    vecs[3]  = '{1'b0, 8'h8E, 8'h05};
    vecs[4]  = '{1'b1, 8'h8E, 8'h0B};
    vecs[5]  = '{1'b1, 8'h8E, 8'h16};
    vecs[6]  = '{1'b1, 8'h8E, 8'h2C};
    vecs[7]  = '{1'b1, 8'hB8, 8'h58};
    vecs[8]  = '{1'b1, 8'hB8, 8'hB0};
    vecs[9]  = '{1'b0, 8'hB8, 8'hB0};
    vecs[10] = '{1'b1, 8'h8E, 8'h61};
    vecs[11] = '{1'b1, 8'h81, 8'hC3};
    for (int i = 0; i < 12; i++)
      apply($sformatf("vec%0d", i), vecs[i].en, vecs[i].tp, vecs[i].exp_seq);

    // hold after 4 enabled steps
    do_reset();
    apply("hold_s1", 1'b1, TAPS_REF, 8'h02);
    apply("hold_s2", 1'b1, TAPS_REF, 8'h05);
    apply("hold_s3", 1'b1, TAPS_REF, 8'h0B);
    apply("hold_s4", 1'b1, TAPS_REF, 8'h16);
    for (int i = 0; i < 4; i++)
      apply($sformatf("hold%0d", i), 1'b0, TAPS_REF, 8'h16);

    // full period
    do_reset();
    hit  = '0;
    dups = 0;
    @(negedge clk);
    taps   = TAPS_REF;
    enable = 1'b1;
    for (int k = 0; k < 256; k++) begin
      if (k != 0) begin
        @(posedge clk);
        #1;
      end
      v = seq;
      if (hit[v]) dups++;
      hit[v] = 1'b1;
    end
    @(posedge clk);
    #1;
    check("period_wrap", seq, 8'h01);
    n_checks++;
    if (dups != 0) begin
      n_fail++;
      $display("FAIL period_dups: repeats=%0d expected=0", dups);
    end
    n_checks++;
    if (hit !== {256{1'b1}}) begin
      n_fail++;
      $display("FAIL period_cover: hit_map=%h expected all ones", hit);
    end

    // zero insertion: walk to 80, then expect 00, 01
    steps = 0;
    while (seq !== 8'h80 && steps < 300) begin
      @(posedge clk);
      #1;
      steps++;
    end
    if (seq !== 8'h80) begin
      n_checks++;
      n_fail++;
      $display("FAIL zero_find: seq=%h never reached 80 within %0d steps", seq, steps);
    end else begin
      @(posedge clk);
      #1;
      check("zero_80_to_00", seq, 8'h00);
      @(posedge clk);
      #1;
      check("zero_00_to_01", seq, 8'h01);
    end
    @(posedge clk);
    #1;
    check("pre_async", seq, 8'h02);

    // async reset between edges while enabled
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1 check("async_immediate", seq, 8'h01);
    @(posedge clk);
    #1 check("async_held", seq, 8'h01);
    @(negedge clk);
    rst_n  = 1'b1;
    enable = 1'b0;
    @(posedge clk);
    #1 check("async_release", seq, 8'h01);
    apply("async_resume", 1'b1, TAPS_REF, 8'h02);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
